sw_debounce: RTL and testbench
==============================

# sw_debounce

Input conditioner that sits directly upstream of the hex display/adder path. It synchronises and debounces a bank of slide switches (or push buttons) and presents clean, stable levels, plus optional one-cycle change pulses, to downstream logic such as the switch-driven adder feeding the 7-segment multiplexer. Each bit has its own debounce FSM. All bits share one tick generator.

## Interface
- `N`, default 8: number of switch bits.
- `TICK_W`, default 20: tick period P = 2^TICK_W clocks (about 10.5 ms at 100 MHz).
- `clk`, input, 1: system clock; all state on the rising edge.
- `reset_n`, input, 1: reset, asynchronous assert and active-low.
- `sw_in`, input, N: raw, asynchronous switch inputs.
- `db_level`, output, N: debounced level per bit.
- `db_rise`, output, N: one-cycle pulse when `db_level[i]` goes 0→1.
- `db_fall`, output, N: one-cycle pulse when `db_level[i]` goes 1→0.

## Operation
- **Synchroniser.** Each `sw_in` bit passes through a 2-FF synchroniser; its output is `s[i]`. Reset value is 0.
- **Tick generator.** A free-running TICK_W-bit counter resets to 0. `tick` is asserted for one cycle when the counter equals all-ones, then the counter wraps to 0.
- **Per-bit FSM.** States are ZERO, WAIT1, ONE, WAIT0. Each bit has a 2-bit stability counter `cnt`.
  - ZERO: if `s=1`, go to WAIT1 and load `cnt=N_STABLE-1` (2).
  - WAIT1, if `s=0`: return to ZERO. No output change.
  - WAIT1, if `s=1` and `tick` and `cnt=0`: go to ONE and pulse `db_rise`.
  - WAIT1, if `s=1` and `tick` and `cnt≠0`: decrement `cnt`.
  - WAIT1, if `s=1` and no `tick`: hold.
  - ONE and WAIT0: mirror image of ZERO and WAIT1, with `s=0` as the trigger. Exit from WAIT0 to ZERO pulses `db_fall`.
- **Outputs.** `db_level[i]=1` in ONE and WAIT0, 0 otherwise. All outputs are registered or decoded from state, with no path from `sw_in`.
- **Bit independence.** Bits are fully independent. Any subset may change in the same cycle.
- **Glitch rejection.** A bounce that returns to the old level before the third qualifying tick causes no output change and fully restarts qualification.

## Timing
- Reset values: all FSMs in ZERO; `db_level=0`, `db_rise=0`, `db_fall=0`; tick counter 0; synchronisers 0.
- Reset asserted mid-qualification aborts immediately. No pulse is emitted.
- After reset release, a switch already high qualifies as a normal rise and produces one `db_rise`.
- Sync latency is 2 cycles; WAIT entry takes 1 further cycle.
- Qualification in WAIT takes 3 ticks, i.e. between 2P+1 and 3P cycles depending on tick phase.
- Total latency from a stable `sw_in` edge to `db_level` change is between 2P+4 and 3P+3 cycles.
- A tick in the same cycle as the WAIT-entry transition is not counted. The tick in the exit cycle is counted.
- `db_rise` and `db_fall` are high for exactly one cycle, coincident with the first cycle of the new `db_level`.
- Inputs that toggle faster than P never change `db_level`.

## Configuration
- `SW_DB_EDGE_EN`
  - Defined: `db_rise` and `db_fall` are generated as described above.
  - Undefined: both outputs are tied to 0 and their logic is removed. Port list, `db_level` behaviour and latency are unchanged.

## Structure
- Package `sw_db_pkg`:
  - enum `db_state_t {ZERO, WAIT1, ONE, WAIT0}`;
  - localparam `N_STABLE = 3`;
  - localparam `CNT_W = 2`.
- Sub-module `db_fsm`: single-bit synchroniser plus FSM. Ports are `clk`, `reset_n`, `tick`, `sw`, `level`, `rise`, `fall`.
- Top `sw_debounce`: holds the shared tick counter and a generate loop of N `db_fsm` instances.

## Test plan
All scenarios use TICK_W=4 (P=16), unless noted otherwise.
- **Reset:** hold `reset_n=0` with `sw_in=8'hFF` → all outputs 0. Release → exactly one `db_rise=8'hFF` pulse between 36 and 51 cycles later, then `db_level=8'hFF` stays.
- **Clean edge:** `sw_in[0]` 0→1 and held → `db_level=8'h01` after 36–51 cycles. `db_rise[0]` is high for 1 cycle and `db_fall` stays 0.
- **Bounce:** `sw_in[3]` toggles every 5 cycles for 200 cycles, then settles at 1 → no output activity during bouncing. A single `db_rise[3]` follows the last toggle within 51 cycles.
- **Mixed simultaneous:** `sw_in` changes 8'h0F→8'hF0 → `db_rise=8'hF0` and `db_fall=8'h0F` asserted in the same cycle.
- **Reset mid-qualification:** assert `reset_n=0` during WAIT1 → outputs stay 0 and no pulse appears.
- **Macro off:** build without `SW_DB_EDGE_EN` and rerun the clean-edge scenario → same `db_level` timing, with `db_rise` and `db_fall` constantly 0.

Source files
------------

// File: rtl/sw_db_pkg.sv
// Shared types and constants for the switch debouncer.
package sw_db_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  localparam int N_STABLE = 3;
  localparam int CNT_W    = 2;

  // Debounced level implied by a state: high once a rise has qualified.
  function automatic logic level_of(db_state_t st);
    return (st == ONE) || (st == WAIT0);
  endfunction

endpackage

// File: rtl/db_fsm.sv
// Single-bit 2-FF synchroniser plus debounce FSM.
// Edge pulses are only generated when SW_DB_EDGE_EN is defined.
module db_fsm
  import sw_db_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic             sync1;
  logic             s;
  db_state_t        state;
  db_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= sw;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ZERO;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A bounce back to the old level drops straight to the stable state,
  // so qualification always restarts from a full count.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ZERO: begin
        if (s) begin
          state_next = WAIT1;
          cnt_next   = CNT_W'(N_STABLE - 1);
        end
      end
      WAIT1: begin
        if (!s) begin
          state_next = ZERO;
        end else if (tick) begin
          if (cnt == '0) state_next = ONE;
          else           cnt_next   = cnt - CNT_W'(1);
        end
      end
      ONE: begin
        if (!s) begin
          state_next = WAIT0;
          cnt_next   = CNT_W'(N_STABLE - 1);
        end
      end
      WAIT0: begin
        if (s) begin
          state_next = ONE;
        end else if (tick) begin
          if (cnt == '0) state_next = ZERO;
          else           cnt_next   = cnt - CNT_W'(1);
        end
      end
      default: state_next = ZERO;
    endcase
  end

  assign level = level_of(state);

`ifdef SW_DB_EDGE_EN
  // Pulses are registered off the qualifying transition so they line up
  // with the first cycle of the new level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= (state == WAIT1) && (state_next == ONE);
      fall <= (state == WAIT0) && (state_next == ZERO);
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Switch-bank debouncer: one shared tick generator feeding N per-bit FSMs.
module sw_debounce
  import sw_db_pkg::*;
#(
  parameter int N      = 8,
  parameter int TICK_W = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] sw_in,
  output logic [N-1:0] db_level,
  output logic [N-1:0] db_rise,
  output logic [N-1:0] db_fall
);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tick_cnt <= '0;
    else          tick_cnt <= tick_cnt + TICK_W'(1);
  end

  assign tick = &tick_cnt;

  for (genvar i = 0; i < N; i++) begin : g_bit
    db_fsm u_fsm (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .sw      (sw_in[i]),
      .level   (db_level[i]),
      .rise    (db_rise[i]),
      .fall    (db_fall[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with a short tick period (P = 16).
module tb_sw_debounce;

  localparam int N      = 8;
  localparam int TICK_W = 4;
  localparam int LAT_MIN = 36;
  localparam int LAT_MAX = 51;

`ifdef SW_DB_EDGE_EN
  localparam logic [N-1:0] EDGE_MASK = 8'hFF;
`else
  localparam logic [N-1:0] EDGE_MASK = 8'h00;
`endif

  typedef struct {
    logic [N-1:0] sw;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] sw_in;
  logic [N-1:0] db_level;
  logic [N-1:0] db_rise;
  logic [N-1:0] db_fall;

  int   check_count = 0;
  int   pass_count  = 0;
  vec_t exp_q[$];
  vec_t vecs[7];

  sw_debounce #(.N(N), .TICK_W(TICK_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw_in    (sw_in),
    .db_level (db_level),
    .db_rise  (db_rise),
    .db_fall  (db_fall)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    check_count++;
    if (act >= lo && act <= hi) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Drive a new switch pattern on the falling edge and queue its expected result.
  task automatic applyStimulus(input vec_t v);
    exp_q.push_back(v);
    @(negedge clk);
    sw_in = v.sw;
  endtask

  // Wait for the level to move, then compare against the oldest queued expectation.
  task automatic checkOutput(input string name, input logic [N-1:0] old_level);
    int   lat   = 0;
    bit   early = 0;
    vec_t e;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (db_level !== old_level) begin
        lat = k;
        break;
      end
      if (db_rise !== '0 || db_fall !== '0) early = 1;
    end
    e = exp_q.pop_front();
    checkRange({name, "_latency"}, lat, LAT_MIN, LAT_MAX);
    checkValue({name, "_no_early_pulse"}, 32'(early), 32'd0);
    checkValue({name, "_level"}, 32'(db_level), 32'(e.level));
    checkValue({name, "_rise"}, 32'(db_rise), 32'(e.rise));
    checkValue({name, "_fall"}, 32'(db_fall), 32'(e.fall));
    @(posedge clk); #1;
    checkValue({name, "_rise_one_cycle"}, 32'(db_rise), 32'd0);
    checkValue({name, "_fall_one_cycle"}, 32'(db_fall), 32'd0);
    checkValue({name, "_level_hold"}, 32'(db_level), 32'(e.level));
  endtask

  initial begin
    vec_t v;
    bit   noisy;

    vecs[0] = '{sw: 8'h00, level: 8'h00, rise: 8'h00, fall: 8'hFF & EDGE_MASK};
    vecs[1] = '{sw: 8'h01, level: 8'h01, rise: 8'h01 & EDGE_MASK, fall: 8'h00};
    vecs[2] = '{sw: 8'h0F, level: 8'h0F, rise: 8'h0E & EDGE_MASK, fall: 8'h00};
    vecs[3] = '{sw: 8'hF0, level: 8'hF0, rise: 8'hF0 & EDGE_MASK, fall: 8'h0F & EDGE_MASK};
    vecs[4] = '{sw: 8'hA5, level: 8'hA5, rise: 8'h05 & EDGE_MASK, fall: 8'h50 & EDGE_MASK};
    vecs[5] = '{sw: 8'h5A, level: 8'h5A, rise: 8'h5A & EDGE_MASK, fall: 8'hA5 & EDGE_MASK};
    vecs[6] = '{sw: 8'h00, level: 8'h00, rise: 8'h00, fall: 8'h5A & EDGE_MASK};

    // Reset held with all switches high: outputs must stay low.
    reset_n = 1'b0;
    sw_in   = 8'hFF;
    repeat (5) @(posedge clk);
    #1;
    checkValue("reset_level", 32'(db_level), 32'd0);
    checkValue("reset_rise", 32'(db_rise), 32'd0);
    checkValue("reset_fall", 32'(db_fall), 32'd0);

    // Release: switches already high qualify as an ordinary rise.
    applyStimulus('{sw: 8'hFF, level: 8'hFF, rise: 8'hFF & EDGE_MASK, fall: 8'h00});
    reset_n = 1'b1;
    checkOutput("reset_release", 8'h00);

    for (int i = 0; i < 7; i++) begin
      logic [N-1:0] prev;
      prev = (i == 0) ? 8'hFF : vecs[i-1].level;
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), prev);
    end

    // Bit 3 bounces every 5 cycles: nothing may move on the outputs.
    noisy = 0;
    for (int i = 0; i < 200; i++) begin
      if (i % 5 == 0) begin
        @(negedge clk);
        sw_in[3] = ~sw_in[3];
      end
      @(posedge clk); #1;
      if (db_level !== 8'h00 || db_rise !== '0 || db_fall !== '0) noisy = 1;
    end
    checkValue("bounce_quiet", 32'(noisy), 32'd0);
    applyStimulus('{sw: 8'h08, level: 8'h08, rise: 8'h08 & EDGE_MASK, fall: 8'h00});
    checkOutput("bounce_settle", 8'h00);

    // Reset asserted while the other bits are still qualifying.
    v = '{sw: 8'hFF, level: 8'hFF, rise: 8'hF7, fall: 8'h00};
    @(negedge clk);
    sw_in = v.sw;
    repeat (20) @(posedge clk);
    #1;
    checkValue("midqual_level_before", 32'(db_level), 32'h08);
    @(negedge clk);
    reset_n = 1'b0;
    sw_in   = 8'h00;
    #1;
    checkValue("midqual_reset_level", 32'(db_level), 32'd0);
    checkValue("midqual_reset_rise", 32'(db_rise), 32'd0);
    checkValue("midqual_reset_fall", 32'(db_fall), 32'd0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    noisy = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (db_level !== 8'h00 || db_rise !== '0 || db_fall !== '0) noisy = 1;
    end
    checkValue("midqual_no_activity", 32'(noisy), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
